sustain_release: RTL and testbench
==================================

# sustain_release

Downstream envelope stage: takes over a voice when the decay stage pulses `start_sustain`, holding the sample at the attenuation the decay stage reached (`shift_amount`). On gate release it steps the attenuation up one bit-shift per programmable number of envelope ticks until the voice is silent, then signals completion to the voice allocator. Single clock domain; the envelope rate is a one-cycle `tick` enable, not a second clock.

## Interface
- `WIDTH`, 20, sample width (two's complement)
- `SHIFT_W`, 5, width of shift/rate fields
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `tick`  in  1  envelope-rate enable, one-cycle pulse, any spacing ≥1 cycle
- `in`  in  WIDTH  oscillator sample
- `start_sustain`  in  1  one-cycle pulse from decay stage: enter sustain
- `shift_amount`  in  SHIFT_W  decay stage's final attenuation, sampled on `start_sustain`
- `gate`  in  1  note held (1) / released (0)
- `release_amount`  in  SHIFT_W  release rate: shift increments every `release_amount`+1 ticks
- `out`  out  WIDTH  attenuated sample, registered
- `shift_out`  out  SHIFT_W  current attenuation shift
- `active`  out  1  high in SUSTAIN or RELEASE
- `voice_done`  out  1  one-cycle pulse when release completes

## Operation
- States: IDLE, SUSTAIN, RELEASE.
- Attenuation: `out` = 0 if `shift_reg` ≥ WIDTH, else `in` arithmetically right-shifted by `shift_reg`; in IDLE `out` = 0.
- IDLE: `start_sustain`=1 → latch `shift_amount` into `shift_reg`, clear tick counter, go SUSTAIN.
- SUSTAIN: `shift_reg` held. `gate`=0 → go RELEASE, clear tick counter.
- RELEASE: on each `tick`, if counter == `release_amount`, counter ← 0 and `shift_reg` ← `shift_reg`+1; else counter+1. When the increment makes `shift_reg` = WIDTH (or `shift_reg` already ≥ WIDTH at a step), go IDLE, pulse `voice_done`, `shift_reg` ← 0.
- `release_amount` is sampled live each tick; changes take effect at the next comparison.
- Priorities:
  - `start_sustain` beats everything in any state (retrigger: re-latch shift, clear counter, go SUSTAIN, no `voice_done`).
  - In IDLE with `start_sustain`=1 and `gate`=0: go SUSTAIN; RELEASE follows next cycle.
  - In SUSTAIN, `gate`=0 and `tick`=1 in the same cycle: transition only, that tick is not counted.
- `shift_amount` ≥ WIDTH latched: `out` = 0 throughout; first release step completes the voice.
- `shift_reg` saturates; it never wraps past 2^SHIFT_W−1.
- `gate` rising while in RELEASE is ignored; only `start_sustain` re-enters SUSTAIN.

## Timing
- Reset (async assert, sync deassert by the system): `out`=0, `shift_out`=0, `active`=0, `voice_done`=0, state IDLE, counter 0.
- `out` latency: 1 cycle from `in`, using the `shift_reg` value of the same cycle.
- `start_sustain` at edge N → `active`=1 and `shift_out`=`shift_amount` after edge N; `out` attenuated from edge N+1 sample.
- Release step cadence: exactly `release_amount`+1 ticks per shift increment; total release = (WIDTH − initial shift) × (`release_amount`+1) ticks.
- `voice_done` high for exactly the cycle after the completing edge; `active` low in that same cycle.
- Reset mid-RELEASE: immediate return to IDLE, no `voice_done`.

## Test plan
- Reset mid-operation: assert `rst_n`=0 in RELEASE → all outputs 0 asynchronously, no `voice_done` pulse after release.
- Sustain hold: `in`=20'h7FFFF, `start_sustain` with `shift_amount`=3, `gate`=1 for 50 ticks → `out`=20'h0FFFF constant, `shift_out`=3.
- Negative sample: `in`=20'h80000, shift 4 → `out`=20'hF8000.
- Release cadence: shift 18, `release_amount`=2, `gate`→0 → `shift_out` 19 after 3 ticks, voice done after 6 ticks, `voice_done` one cycle, `out`=0.
- Retrigger: during RELEASE at `shift_out`=10, pulse `start_sustain` with `shift_amount`=2 → SUSTAIN, `shift_out`=2, no `voice_done`.
- Edge values: `shift_amount`=25 → `out`=0 in SUSTAIN, done on first release step; `release_amount`=0 → one step per tick.

Source files
------------

// File: rtl/sustain_release.sv
// sustain_release
// Downstream envelope stage. Holds a voice at the attenuation handed over by
// the decay stage while the gate is held. After gate release it raises the
// attenuation by one bit-shift every (release_amount+1) envelope ticks until
// the voice is silent, then pulses voice_done to the voice allocator.
//
// Pulse protocol: start_sustain, tick and voice_done are single-cycle
// strobes qualified only by the rising clock edge. There is no
// backpressure. A strobe is consumed on the edge where it is seen high, and
// voice_done is high for exactly one cycle.
module sustain_release #(
    parameter int WIDTH   = 20,
    parameter int SHIFT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic [WIDTH-1:0]   in,
    input  logic               start_sustain,
    input  logic [SHIFT_W-1:0] shift_amount,
    input  logic               gate,
    input  logic [SHIFT_W-1:0] release_amount,
    output logic [WIDTH-1:0]   out,
    output logic [SHIFT_W-1:0] shift_out,
    output logic               active,
    output logic               voice_done,
    output logic [1:0]         dbg_state
);

    // State encoding, kept as plain constants so it is easy to bind checkers.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SUSTAIN = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    // WIDTH expressed in the one-bit-wider shift arithmetic so that the
    // incremented shift can be compared without overflowing.
    localparam logic [SHIFT_W:0] WIDTH_EXT = (SHIFT_W+1)'(WIDTH);

    // Registered state
    logic [1:0]         r_state;
    logic [SHIFT_W-1:0] r_shift;
    logic [SHIFT_W-1:0] r_cnt;
    logic               r_done;
    logic [WIDTH-1:0]   r_out;

    // Next-state values
    logic [1:0]         w_state_nxt;
    logic [SHIFT_W-1:0] w_shift_nxt;
    logic [SHIFT_W-1:0] w_cnt_nxt;
    logic               w_done_nxt;

    // Helper terms
    logic [SHIFT_W:0]   w_shift_inc;   // r_shift + 1 with a carry bit
    logic [SHIFT_W-1:0] w_shift_sat;   // r_shift + 1, held at the all-ones value
    logic               w_step_done;   // this step reaches or passes silence
    logic               w_in_range;    // current shift still lets signal through
    logic               w_step;        // a release step is taken this cycle
    logic [WIDTH-1:0]   w_atten;       // arithmetically shifted sample

    // Shift increment, kept one bit wider so the saturation check sees the carry.
    assign w_shift_inc = {1'b0, r_shift} + (SHIFT_W+1)'(1);
    assign w_shift_sat = w_shift_inc[SHIFT_W] ? r_shift : w_shift_inc[SHIFT_W-1:0];

    // Finishing on "incremented value >= WIDTH" covers both the normal case
    // (the increment lands on WIDTH) and a voice latched above WIDTH, which
    // must finish on its very first release step.
    assign w_step_done = (w_shift_inc >= WIDTH_EXT);

    assign w_in_range = ({1'b0, r_shift} < WIDTH_EXT);

    // A release step happens when a tick arrives with the counter at the live rate.
    assign w_step = tick && (r_cnt == release_amount);

    // Arithmetic right shift keeps the sign of the two's-complement sample.
    assign w_atten = $signed(in) >>> r_shift;

    // Next-state logic: start_sustain wins in every state, then per-state rules.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;

        if (start_sustain) begin
            // Entry or retrigger: re-latch the attenuation and restart the count.
            w_state_nxt = ST_SUSTAIN;
            w_shift_nxt = shift_amount;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_shift_nxt = '0;
                    w_cnt_nxt   = '0;
                end

                ST_SUSTAIN: begin
                    // A tick arriving together with the release is not counted.
                    if (!gate) begin
                        w_state_nxt = ST_RELEASE;
                        w_cnt_nxt   = '0;
                    end
                end

                ST_RELEASE: begin
                    // The gate is deliberately ignored here. Only start_sustain
                    // brings the voice back to SUSTAIN.
                    if (w_step) begin
                        w_cnt_nxt = '0;
                        if (w_step_done) begin
                            w_state_nxt = ST_IDLE;
                            w_shift_nxt = '0;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_shift_nxt = w_shift_sat;
                        end
                    end else if (tick) begin
                        w_cnt_nxt = r_cnt + SHIFT_W'(1);
                    end
                end

                default: begin
                    w_state_nxt = ST_IDLE;
                    w_shift_nxt = '0;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State, shift, tick counter and the completion strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Output sample: one-cycle latency, attenuated with this cycle's shift.
    // The output is silent in IDLE or once the shift reaches the sample width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else if ((r_state == ST_IDLE) || !w_in_range) begin
            r_out <= '0;
        end else begin
            r_out <= w_atten;
        end
    end

    assign out        = r_out;
    assign shift_out  = r_shift;
    assign active     = (r_state != ST_IDLE);
    assign voice_done = r_done;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_sustain_release.sv
// tb_sustain_release
// Directed scenarios followed by a randomized run against a behavioural
// envelope model.
module tb_sustain_release;

  localparam int WIDTH   = 20;
  localparam int SHIFT_W = 5;

  logic               clk;
  logic               rst_n;
  logic               tick;
  logic [WIDTH-1:0]   din;
  logic               start_sustain;
  logic [SHIFT_W-1:0] shift_amount;
  logic               gate;
  logic [SHIFT_W-1:0] release_amount;
  logic [WIDTH-1:0]   dout;
  logic [SHIFT_W-1:0] shift_out;
  logic               active;
  logic               voice_done;
  logic [1:0]         dbg_state;

  int n_checks;
  int n_errors;

  // Behavioural model: voice mode, current attenuation, and ticks seen in
  // the current release step.
  int         m_mode;   // 0 silent, 1 holding, 2 releasing
  int         m_shift;
  int         m_ticks;
  logic [WIDTH-1:0] m_out;
  logic       m_done;

  sustain_release #(.WIDTH(WIDTH), .SHIFT_W(SHIFT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tick           (tick),
    .in             (din),
    .start_sustain  (start_sustain),
    .shift_amount   (shift_amount),
    .gate           (gate),
    .release_amount (release_amount),
    .out            (dout),
    .shift_out      (shift_out),
    .active         (active),
    .voice_done     (voice_done),
    .dbg_state      (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Floor division by 2^s of a signed sample, or 0 once fully attenuated.
  function automatic logic [WIDTH-1:0] model_atten(input logic [WIDTH-1:0] x, input int s);
    int v;
    int d;
    int q;
    logic [31:0] qq;
    if (s >= WIDTH) return '0;
    v = x[WIDTH-1] ? (int'(x) - (1 << WIDTH)) : int'(x);
    d = 1 << s;
    if (v >= 0) q = v / d;
    else q = -(((-v) + d - 1) / d);
    qq = q;
    return qq[WIDTH-1:0];
  endfunction

  // One clock edge: advance the model from the inputs seen at the edge.
  task automatic cycle();
    @(posedge clk);
    if (!rst_n) begin
      m_mode = 0; m_shift = 0; m_ticks = 0; m_out = '0; m_done = 1'b0;
    end else begin
      m_out  = (m_mode != 0) ? model_atten(din, m_shift) : '0;
      m_done = 1'b0;
      if (start_sustain) begin
        m_mode = 1; m_shift = int'(shift_amount); m_ticks = 0;
      end else if (m_mode == 1 && !gate) begin
        m_mode = 2; m_ticks = 0;
      end else if (m_mode == 2 && tick) begin
        m_ticks = m_ticks + 1;
        if (m_ticks == int'(release_amount) + 1) begin
          m_ticks = 0;
          if (m_shift + 1 >= WIDTH) begin
            m_mode = 0; m_shift = 0; m_done = 1'b1;
          end else begin
            m_shift = m_shift + 1;
          end
        end
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    tick = 0; din = '0; start_sustain = 0; shift_amount = '0; gate = 0; release_amount = '0;
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (dout !== '0 || shift_out !== '0 || active !== 1'b0 || voice_done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state out=%h shift=%0d active=%b done=%b expected all 0", dout, shift_out, active, voice_done);
    end
    apply_reset();
    cycle();
    n_checks++;
    if (dout !== '0 || active !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_after_reset out=%h active=%b expected 0/0", dout, active);
    end
  endtask

  task automatic test_sustain_hold();
    din = 20'h7FFFF; gate = 1; start_sustain = 1; shift_amount = 5'd3;
    cycle();
    start_sustain = 0;
    n_checks++;
    if (active !== 1'b1 || shift_out !== 5'd3) begin
      n_errors++;
      $display("FAIL sustain_entry active=%b shift=%0d expected 1/3", active, shift_out);
    end
    for (int i = 0; i < 100; i++) begin
      tick = (i % 2 == 0);
      cycle();
      n_checks++;
      if (dout !== 20'h0FFFF || shift_out !== 5'd3 || active !== 1'b1) begin
        n_errors++;
        $display("FAIL sustain_hold cyc=%0d out=%h shift=%0d expected 0ffff/3", i, dout, shift_out);
      end
    end
    tick = 0;
  endtask

  task automatic test_negative();
    din = 20'h80000; start_sustain = 1; shift_amount = 5'd4; gate = 1;
    cycle();
    start_sustain = 0;
    cycle();
    n_checks++;
    if (dout !== 20'hF8000) begin
      n_errors++;
      $display("FAIL negative_sample out=%h expected f8000", dout);
    end
  endtask

  task automatic test_release_cadence();
    din = 20'h7FFFF; start_sustain = 1; shift_amount = 5'd18; gate = 1; release_amount = 5'd2;
    cycle();
    start_sustain = 0; gate = 0;
    cycle();
    for (int k = 1; k <= 6; k++) begin
      tick = 1;
      cycle();
      tick = 0;
      if (k == 2) begin
        n_checks++;
        if (shift_out !== 5'd18 || voice_done !== 1'b0) begin
          n_errors++;
          $display("FAIL release_tick2 shift=%0d done=%b expected 18/0", shift_out, voice_done);
        end
      end
      if (k == 3) begin
        n_checks++;
        if (shift_out !== 5'd19 || active !== 1'b1) begin
          n_errors++;
          $display("FAIL release_tick3 shift=%0d active=%b expected 19/1", shift_out, active);
        end
      end
      if (k == 5) begin
        n_checks++;
        if (voice_done !== 1'b0 || active !== 1'b1) begin
          n_errors++;
          $display("FAIL release_tick5 done=%b active=%b expected 0/1", voice_done, active);
        end
      end
      if (k == 6) begin
        n_checks++;
        if (voice_done !== 1'b1 || active !== 1'b0 || shift_out !== '0) begin
          n_errors++;
          $display("FAIL release_done done=%b active=%b shift=%0d expected 1/0/0", voice_done, active, shift_out);
        end
      end
      cycle();
      if (k == 6) begin
        n_checks++;
        if (voice_done !== 1'b0 || dout !== '0) begin
          n_errors++;
          $display("FAIL done_one_cycle done=%b out=%h expected 0/00000", voice_done, dout);
        end
      end
    end
  endtask

  task automatic test_retrigger();
    start_sustain = 1; shift_amount = 5'd8; gate = 1; release_amount = 5'd0;
    cycle();
    start_sustain = 0; gate = 0;
    cycle();
    for (int k = 0; k < 2; k++) begin
      tick = 1; cycle(); tick = 0; cycle();
    end
    n_checks++;
    if (shift_out !== 5'd10) begin
      n_errors++;
      $display("FAIL retrig_pre shift=%0d expected 10", shift_out);
    end
    gate = 1; start_sustain = 1; shift_amount = 5'd2; tick = 1;
    cycle();
    start_sustain = 0;
    n_checks++;
    if (shift_out !== 5'd2 || active !== 1'b1 || voice_done !== 1'b0) begin
      n_errors++;
      $display("FAIL retrigger shift=%0d active=%b done=%b expected 2/1/0", shift_out, active, voice_done);
    end
    for (int k = 0; k < 6; k++) begin
      cycle();
      n_checks++;
      if (shift_out !== 5'd2 || voice_done !== 1'b0) begin
        n_errors++;
        $display("FAIL retrig_hold shift=%0d done=%b expected 2/0", shift_out, voice_done);
      end
    end
    tick = 0;
  endtask

  task automatic test_edge_values();
    din = 20'h7FFFF; start_sustain = 1; shift_amount = 5'd25; gate = 1;
    cycle();
    start_sustain = 0;
    cycle();
    n_checks++;
    if (dout !== '0 || shift_out !== 5'd25 || active !== 1'b1) begin
      n_errors++;
      $display("FAIL big_shift_sustain out=%h shift=%0d active=%b expected 0/25/1", dout, shift_out, active);
    end
    gate = 0; release_amount = 5'd3;
    cycle();
    for (int k = 1; k <= 4; k++) begin
      tick = 1; cycle(); tick = 0;
      n_checks++;
      if (voice_done !== (k == 4) || active !== (k != 4)) begin
        n_errors++;
        $display("FAIL big_shift_release tick=%0d done=%b active=%b", k, voice_done, active);
      end
      cycle();
    end
    // One step per tick with a zero release rate.
    start_sustain = 1; shift_amount = 5'd17; gate = 1; release_amount = 5'd0;
    cycle();
    start_sustain = 0; gate = 0;
    cycle();
    for (int k = 1; k <= 3; k++) begin
      tick = 1; cycle(); tick = 0;
      n_checks++;
      if (k < 3 && (shift_out !== 5'(17 + k) || voice_done !== 1'b0)) begin
        n_errors++;
        $display("FAIL rate0_step tick=%0d shift=%0d expected %0d", k, shift_out, 17 + k);
      end else if (k == 3 && voice_done !== 1'b1) begin
        n_errors++;
        $display("FAIL rate0_done done=%b expected 1", voice_done);
      end
      cycle();
    end
  endtask

  task automatic test_idle_start_gate_low();
    start_sustain = 1; shift_amount = 5'd5; gate = 0; release_amount = 5'd0;
    cycle();
    start_sustain = 0;
    n_checks++;
    if (active !== 1'b1 || shift_out !== 5'd5) begin
      n_errors++;
      $display("FAIL idle_start_gate0 active=%b shift=%0d expected 1/5", active, shift_out);
    end
    cycle();
    tick = 1; cycle(); tick = 0;
    n_checks++;
    if (shift_out !== 5'd6) begin
      n_errors++;
      $display("FAIL release_follows shift=%0d expected 6", shift_out);
    end
  endtask

  task automatic test_reset_mid_release();
    tick = 1; cycle(); tick = 0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (dout !== '0 || shift_out !== '0 || active !== 1'b0 || voice_done !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset out=%h shift=%0d active=%b done=%b expected 0", dout, shift_out, active, voice_done);
    end
    cycle();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick = 1;
      cycle();
      n_checks++;
      if (voice_done !== 1'b0 || active !== 1'b0) begin
        n_errors++;
        $display("FAIL post_reset_quiet done=%b active=%b expected 0/0", voice_done, active);
      end
    end
    tick = 0;
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 6000; i++) begin
      din  = WIDTH'($urandom);
      tick = ($urandom_range(0, 2) == 0);
      start_sustain = ($urandom_range(0, 150) == 0);
      if (start_sustain) begin
        shift_amount   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(20, 31)) : 5'($urandom_range(10, 19));
        release_amount = 5'($urandom_range(0, 3));
      end else begin
        shift_amount = 5'($urandom);
      end
      if ($urandom_range(0, 20) == 0) gate = ~gate;
      cycle();
      n_checks++;
      if (dout !== m_out || shift_out !== 5'(m_shift) || active !== (m_mode != 0) || voice_done !== m_done) begin
        n_errors++;
        $display("FAIL random cyc=%0d out=%h/%h shift=%0d/%0d active=%b/%b done=%b/%b (got/expected)",
                 i, dout, m_out, shift_out, m_shift, active, (m_mode != 0), voice_done, m_done);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_mode = 0; m_shift = 0; m_ticks = 0; m_out = '0; m_done = 1'b0;
    test_reset();
    test_sustain_hold();
    test_negative();
    test_release_cadence();
    test_retrigger();
    test_edge_values();
    test_idle_start_gate_low();
    test_reset_mid_release();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
